// File: rtl/vram_arb_pkg.sv
// Shared VRAM bus constants and the arbiter grant encoding.
package vram_arb_pkg;

  localparam int unsigned VRAM_AW = 13;
  localparam int unsigned VRAM_DW = 16;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'b00,
    GNT_VID  = 2'b01,
    GNT_CPU  = 2'b10
  } gnt_e;

endpackage

// File: rtl/vram_arb_timeout.sv
// Stall watchdog for the VRAM port: counts strobed-but-unacked cycles and
// raises a one-cycle abort on the TIMEOUT-th consecutive stalled cycle.
// Only instantiated when VRAM_ARB_TIMEOUT_EN is defined.
module vram_arb_timeout #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  input  logic ack,
  input  logic clr,
  output logic abort
);

  // Counter holds the number of stalled cycles already seen (0..TIMEOUT-1).
  localparam int unsigned    CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Count stalls; ack or a grant change starts a fresh window.
  always_comb begin
    abort = stb & ~ack & (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr || ack)  cnt_d = '0;
    else if (stb)    cnt_d = cnt_q + CW'(1);
  end

endmodule

// File: rtl/vram_arbiter.sv
// Two-master arbiter for the single VRAM Wishbone slave port.
// Video fetcher has priority; CPU is served in the gaps and is pre-empted
// only at beat boundaries. Optional stall timeout: VRAM_ARB_TIMEOUT_EN.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned AW      = VRAM_AW,
  parameter int unsigned DW      = VRAM_DW,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic [AW-1:0]   V_ADR_I,
  input  logic            V_CYC_I,
  input  logic            V_STB_I,
  output logic            V_ACK_O,
  output logic            V_ERR_O,
  input  logic [AW-1:0]   C_ADR_I,
  input  logic [DW-1:0]   C_DAT_I,
  input  logic [DW/8-1:0] C_SEL_I,
  input  logic            C_WE_I,
  input  logic            C_CYC_I,
  input  logic            C_STB_I,
  output logic            C_ACK_O,
  output logic            C_ERR_O,
  output logic [DW-1:0]   RD_DAT_O,
  output logic [AW-1:0]   M_ADR_O,
  output logic [DW-1:0]   M_DAT_O,
  output logic [DW/8-1:0] M_SEL_O,
  output logic            M_WE_O,
  output logic            M_CYC_O,
  output logic            M_STB_O,
  input  logic            M_ACK_I,
  input  logic [DW-1:0]   M_DAT_I,
  output logic [1:0]      GNT_O
);

  gnt_e gnt_q, gnt_d;
  logic cyc_raw, stb_raw;
  logic abort;

  // Grant register.
  always_ff @(posedge CLK_I) begin
    if (RST_I) gnt_q <= GNT_IDLE;
    else       gnt_q <= gnt_d;
  end

  // Grant next-state: video wins ties; CPU yields only on an acked beat.
  always_comb begin
    gnt_d = gnt_q;
    unique case (gnt_q)
      GNT_IDLE: begin
        if (V_CYC_I)      gnt_d = GNT_VID;
        else if (C_CYC_I) gnt_d = GNT_CPU;
      end
      GNT_VID: begin
        if (!V_CYC_I) gnt_d = C_CYC_I ? GNT_CPU : GNT_IDLE;
      end
      GNT_CPU: begin
        if (!C_CYC_I)                          gnt_d = V_CYC_I ? GNT_VID : GNT_IDLE;
        else if (V_CYC_I && M_ACK_I && C_STB_I) gnt_d = GNT_VID;
      end
      default: gnt_d = GNT_IDLE;
    endcase
    if (abort) gnt_d = GNT_IDLE;
  end

  // Slave-side mux driven from the registered grant.
  always_comb begin
    cyc_raw = 1'b0;
    stb_raw = 1'b0;
    M_ADR_O = '0;
    M_DAT_O = '0;
    M_SEL_O = '0;
    M_WE_O  = 1'b0;
    unique case (gnt_q)
      GNT_VID: begin
        cyc_raw = V_CYC_I;
        stb_raw = V_STB_I;
        M_ADR_O = V_ADR_I;
        M_SEL_O = '1;
      end
      GNT_CPU: begin
        cyc_raw = C_CYC_I;
        stb_raw = C_STB_I;
        M_ADR_O = C_ADR_I;
        M_DAT_O = C_DAT_I;
        M_SEL_O = C_SEL_I;
        M_WE_O  = C_WE_I;
      end
      default: ;
    endcase
    M_CYC_O = cyc_raw & ~abort;
    M_STB_O = stb_raw & ~abort;
  end

  // Acks are discarded while reset is asserted so a beat cut by reset is never reported.
  assign V_ACK_O  = M_ACK_I & V_STB_I & (gnt_q == GNT_VID) & ~RST_I;
  assign C_ACK_O  = M_ACK_I & C_STB_I & (gnt_q == GNT_CPU) & ~RST_I;
  assign RD_DAT_O = M_DAT_I;
  assign GNT_O    = gnt_q;

`ifdef VRAM_ARB_TIMEOUT_EN
  vram_arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk   (CLK_I),
    .rst   (RST_I),
    .stb   (stb_raw),
    .ack   (M_ACK_I),
    .clr   (gnt_d != gnt_q),
    .abort (abort)
  );

  assign V_ERR_O = abort & (gnt_q == GNT_VID);
  assign C_ERR_O = abort & (gnt_q == GNT_CPU);
`else
  assign abort   = 1'b0;
  assign V_ERR_O = 1'b0;
  assign C_ERR_O = 1'b0;
`endif

endmodule
